// File: rtl/fadd_share_arbiter.sv
// fadd_share_arbiter
// Shares one 4-stage pipelined floating-point adder between N_REQ requesters.
// Round-robin grant, one issue per cycle, each in-flight op is tagged with its
// owner ID so the result strobe goes back to the requester that issued it.
// Optional feature macro: FADD_ARB_PERF_EN adds a busy-cycle counter
// (perf_clr in, perf_busy out).

module fadd_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int PIPE_LAT = 4,
    parameter int ID_W     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [N_REQ-1:0]     req_op,
    input  logic                 flush,
    output logic                 idle,
    output logic [31:0]          fa_a,
    output logic [31:0]          fa_b,
    output logic                 fa_op,
    input  logic [31:0]          fa_result,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_data
`ifdef FADD_ARB_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_busy
`endif
);

    localparam int INF_W = $clog2(PIPE_LAT + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W-1:0]  next_ptr;
    logic             grant_found;
    logic             arb_en;
    logic             handshake;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             sel_op;
    int               arb_idx;
    logic [PIPE_LAT:0] tag_valid;
    logic [ID_W-1:0]  tag_id [PIPE_LAT+1];
    logic [INF_W-1:0] inflight;
    logic             resp_fire;

    // Round-robin search starting at rr_ptr; the first valid requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_op      = 1'b0;
        arb_idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            arb_idx = int'(rr_ptr) + k;
            if (arb_idx >= N_REQ) begin
                arb_idx = arb_idx - N_REQ;
            end
            if (!grant_found && req_valid[arb_idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(arb_idx);
                sel_a       = req_a[32*arb_idx +: 32];
                sel_b       = req_b[32*arb_idx +: 32];
                sel_op      = req_op[arb_idx];
            end
        end
    end

    // Grant is only offered outside DRAIN and never while flush or reset is high.
    always_comb begin
        arb_en    = !rst && !flush && (state != S_DRAIN);
        handshake = arb_en && grant_found;
        req_ready = '0;
        if (handshake) begin
            req_ready[grant_id] = 1'b1;
        end
        next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        resp_fire = tag_valid[PIPE_LAT];
        idle      = (state == S_IDLE) && (inflight == '0);
    end

    // Pointer moves just past the requester that was served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= next_ptr;
        end
    end

    // Operand registers feeding the adder; they hold between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fa_a  <= '0;
            fa_b  <= '0;
            fa_op <= 1'b0;
        end else if (handshake) begin
            fa_a  <= sel_a;
            fa_b  <= sel_b;
            fa_op <= sel_op;
        end
    end

    // Tag pipe tracks which slot of the adder pipeline carries a real op and its owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid <= '0;
            for (int k = 0; k <= PIPE_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[PIPE_LAT-1:0], handshake};
            tag_id[0] <= grant_id;
            for (int k = 1; k <= PIPE_LAT; k++) begin
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    // Registered result strobe routed to the owner of the op leaving the tag pipe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= '0;
            if (resp_fire) begin
                resp_valid[tag_id[PIPE_LAT]] <= 1'b1;
                resp_data                    <= fa_result;
            end
        end
    end

    // Count of ops issued but not yet returned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({handshake, resp_fire})
                2'b10:   inflight <= inflight + INF_W'(1);
                2'b01:   inflight <= inflight - INF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Control FSM: IDLE until work arrives, RUN while serving, DRAIN while flushing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((|req_valid) && !flush) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (!(|req_valid) && (inflight == '0)) begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if ((inflight == '0) && !flush) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FADD_ARB_PERF_EN
    // Saturating count of cycles with at least one op in the adder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy <= '0;
        end else if (perf_clr) begin
            perf_busy <= '0;
        end else if ((inflight != '0) && (perf_busy != 32'hFFFF_FFFF)) begin
            perf_busy <= perf_busy + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fadd_share_arbiter.sv
// tb_fadd_share_arbiter
// Bench for fadd_share_arbiter with a behavioural 4-stage float adder attached.
// Grant/idle behaviour comes from a vector table; results are tracked by a
// scoreboard that expects each response exactly PIPE_LAT+1 edges after its handshake.
// Build with FADD_ARB_PERF_EN defined to also exercise the perf counter ports.

module tb_fadd_share_arbiter;

    localparam int N_REQ    = 4;
    localparam int PIPE_LAT = 4;
    localparam int ID_W     = 2;

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [32*N_REQ-1:0]  req_a;
    logic [32*N_REQ-1:0]  req_b;
    logic [N_REQ-1:0]     req_op;
    logic                 flush;
    logic                 idle;
    logic [31:0]          fa_a;
    logic [31:0]          fa_b;
    logic                 fa_op;
    logic [31:0]          fa_result;
    logic [N_REQ-1:0]     resp_valid;
    logic [31:0]          resp_data;
`ifdef FADD_ARB_PERF_EN
    logic                 perf_clr;
    logic [31:0]          perf_busy;
`endif

    int errors = 0;
    int checks = 0;
    int edge_cnt = 0;

    // Expected result of each requester's fixed operand pair.
    logic [31:0] exp_res [N_REQ] = '{32'h40400000, 32'h3FC00000, 32'h40000000, 32'h41000000};

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        int              due;
    } sb_entry_t;

    sb_entry_t sb[$];
    sb_entry_t mon_e;
    logic [N_REQ-1:0] mon_hs;
    logic [N_REQ-1:0] mon_onehot;

    typedef struct {
        logic [N_REQ-1:0] valid;
        logic             flush;
        logic [N_REQ-1:0] ready;
        logic             idle;
    } vec_t;

    vec_t vecs [8];

    fadd_share_arbiter #(
        .N_REQ(N_REQ),
        .PIPE_LAT(PIPE_LAT),
        .ID_W(ID_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .req_op(req_op),
        .flush(flush),
        .idle(idle),
        .fa_a(fa_a),
        .fa_b(fa_b),
        .fa_op(fa_op),
        .fa_result(fa_result),
        .resp_valid(resp_valid),
        .resp_data(resp_data)
`ifdef FADD_ARB_PERF_EN
        ,
        .perf_clr(perf_clr),
        .perf_busy(perf_busy)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Behavioural adder: normal numbers only, which covers every operand used here.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [10:0] e64;
        if (f[30:23] == 8'd0) return 0.0;
        e64 = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e64, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b, input logic op);
        real         r;
        logic [63:0] bits;
        logic [10:0] e64;
        r = op ? (f32_to_real(a) - f32_to_real(b)) : (f32_to_real(a) + f32_to_real(b));
        if (r == 0.0) return 32'h0;
        bits = $realtobits(r);
        e64 = bits[62:52];
        return {bits[63], 8'(e64 - 11'd896), bits[51:29]};
    endfunction

    logic [31:0] fp_s1 = 32'h0;
    logic [31:0] fp_s2 = 32'h0;
    logic [31:0] fp_s3 = 32'h0;
    logic [31:0] fp_s4 = 32'h0;

    always @(posedge clk) begin
        fp_s1 <= fp_add(fa_a, fa_b, fa_op);
        fp_s2 <= fp_s1;
        fp_s3 <= fp_s2;
        fp_s4 <= fp_s3;
    end

    assign fa_result = fp_s4;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic fl);
        @(posedge clk);
        #1;
        req_valid = valid;
        flush     = fl;
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'h0);
        checkOutput({tag, "_fa_a"}, fa_a, 32'h0);
        checkOutput({tag, "_fa_b"}, fa_b, 32'h0);
        checkOutput({tag, "_fa_op"}, 32'(fa_op), 32'h0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        checkOutput({tag, "_resp_data"}, resp_data, 32'h0);
        checkOutput({tag, "_idle"}, 32'(idle), 32'h1);
`ifdef FADD_ARB_PERF_EN
        checkOutput({tag, "_perf_busy"}, perf_busy, 32'h0);
`endif
    endtask

    // Scoreboard: record handshakes, then match every response for owner, data and timing.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    checkOutput("stray_resp_valid", 32'(resp_valid), 32'h0);
                end else begin
                    mon_e = sb.pop_front();
                    mon_onehot = '0;
                    mon_onehot[mon_e.id] = 1'b1;
                    checkOutput("resp_owner", 32'(resp_valid), 32'(mon_onehot));
                    checkOutput("resp_data", resp_data, mon_e.data);
                    checkOutput("resp_latency_edge", 32'(edge_cnt), 32'(mon_e.due));
                end
            end else if (sb.size() != 0 && sb[0].due <= edge_cnt) begin
                mon_e = sb.pop_front();
                mon_onehot = '0;
                mon_onehot[mon_e.id] = 1'b1;
                checkOutput("missing_resp", 32'(resp_valid), 32'(mon_onehot));
            end
            mon_hs = req_valid & req_ready;
            for (int k = 0; k < N_REQ; k++) begin
                if (mon_hs[k]) begin
                    mon_e.id   = ID_W'(k);
                    mon_e.data = exp_res[k];
                    mon_e.due  = edge_cnt + 1 + PIPE_LAT + 1;
                    sb.push_back(mon_e);
                end
            end
        end
    end

    initial begin
        // Grant/idle table starting from reset (pointer 0, IDLE).
        vecs[0] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
        vecs[1] = '{4'b0001, 1'b0, 4'b0001, 1'b1};
        vecs[2] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
        vecs[3] = '{4'b1001, 1'b0, 4'b1000, 1'b0};
        vecs[4] = '{4'b1001, 1'b0, 4'b0001, 1'b0};
        vecs[5] = '{4'b0011, 1'b0, 4'b0010, 1'b0};
        vecs[6] = '{4'b0011, 1'b0, 4'b0001, 1'b0};
        vecs[7] = '{4'b0110, 1'b1, 4'b0000, 1'b0};

        req_a  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        req_b  = {32'h40800000, 32'h3F800000, 32'h3F000000, 32'h40000000};
        req_op = 4'b0110;
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 4'b1111;
`ifdef FADD_ARB_PERF_EN
        perf_clr  = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #2;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        req_valid = 4'b0000;
        rst       = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].flush);
            checkOutput($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
            checkOutput($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].idle));
        end
        checkOutput("hold_fa_a", fa_a, 32'h3F800000);
        checkOutput("hold_fa_b", fa_b, 32'h40000000);

        // Flush held: no grants, in-flight ops drain, idle stays low until release.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0110, 1'b1);
            checkOutput($sformatf("flush%0d_ready", i), 32'(req_ready), 32'h0);
            checkOutput($sformatf("flush%0d_idle", i), 32'(idle), 32'h0);
        end
        applyStimulus(4'b0000, 1'b0);
        checkOutput("flush_release_idle_low", 32'(idle), 32'h0);
        checkOutput("flush_drained", 32'(sb.size()), 32'h0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("flush_release_idle_high", 32'(idle), 32'h1);

        // Reset with two ops in flight: everything back to reset values, no stray results.
        applyStimulus(4'b0001, 1'b0);
        checkOutput("rst_issue0_ready", 32'(req_ready), 32'h1);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("rst_issue1_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #3;
        rst       = 1'b1;
        req_valid = 4'b1111;
        #1;
        checkResetValues("midflight_reset");
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0000;
        rst       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0000, 1'b0);
            checkOutput($sformatf("post_rst%0d_resp_valid", i), 32'(resp_valid), 32'h0);
        end

        // Contention from pointer 0: strict rotation, back-to-back responses.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b0);
            checkOutput($sformatf("contend%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0000, 1'b0);
        end
        checkOutput("contend_drained", 32'(sb.size()), 32'h0);
        checkOutput("contend_idle", 32'(idle), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
